// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA writes feed a small FIFO that is
// serialised onto tx; STATUS reports FIFO/transmitter state and sticky overflow.
module io_uart_tx #(
   parameter int unsigned CLK_RATE     = 33_333_333,
   parameter int unsigned BAUD_RATE    = 19_200,
   parameter int unsigned BAUD_DIV     = CLK_RATE / BAUD_RATE,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_7f30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] io_memory_write,
   output logic [31:0] io_memory_read,
   output logic        valid_io_read,
   output logic        tx
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(BAUD_DIV);

   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t             state;
   logic [BAUD_W-1:0]  baud_cnt;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               overflow;

   logic        data_hit;
   logic        status_hit;
   logic        push;
   logic        pop;
   logic        accept;
   logic        drop;
   logic        clear;
   logic        full;
   logic        empty;
   logic        bit_end;
   logic [7:0]  head;
   logic [31:0] count_wide;
   logic [3:0]  count_sat;
   logic [31:0] status_word;
   logic        unused_wdata;

   assign data_hit   = (address == BASE_ADDRESS);
   assign status_hit = (address == BASE_ADDRESS + 32'd4);
   assign push       = MemWrite & data_hit;
   assign clear      = MemWrite & status_hit & io_memory_write[3];
   assign full       = (count == COUNT_FULL);
   assign empty      = (count == '0);
   assign bit_end    = (baud_cnt == BAUD_LAST);
   assign head       = mem[rd_ptr];

   // The head leaves the FIFO when a frame starts from IDLE or chains off a stop bit.
   assign pop    = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   assign unused_wdata = ^{io_memory_write[31:8], io_memory_write[2:0]};

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      count_wide  = 32'(count);
      count_sat   = (count_wide > 32'd15) ? 4'hf : count_wide[3:0];
      status_word = '0;
      status_word[0]   = full;
      status_word[1]   = empty;
      status_word[2]   = (state != S_IDLE);
      status_word[3]   = overflow;
      status_word[7:4] = count_sat;
   end

   // NOTE: the FIFO storage is deliberately left out of reset; empty pointers make stale contents unreachable.
   always_ff @(posedge clk) begin
      if (rst && accept) begin
         mem[wr_ptr] <= io_memory_write[7:0];
      end
   end

   // NOTE: all sequential state is assigned with <= so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         io_memory_read <= '0;
         valid_io_read  <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         overflow       <= 1'b0;
      end else begin
         valid_io_read  <= MemRead & (data_hit | status_hit);
         io_memory_read <= (MemRead & status_hit) ? status_word : 32'd0;

         // A drop in the same cycle as a clear leaves the overflow flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear) begin
            overflow <= 1'b0;
         end

         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (pop) begin
                  shift <= head;
                  state <= S_START;
                  tx    <= 1'b0;
               end
            end

            S_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= S_DATA;
                  tx       <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  bit_idx  <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                     tx    <= 1'b1;
                  end else begin
                     tx <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift <= head;
                     state <= S_START;
                     tx    <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: bus stimulus in one sequence, a serial
// receiver decodes tx frames and checks them against a scoreboard queue.
module tb_io_uart_tx;

   localparam logic [31:0] DATA_A  = 32'h0000_7f30;
   localparam logic [31:0] STAT_A  = 32'h0000_7f34;
   localparam logic [31:0] UNMAP_A = 32'h0000_7f38;
   localparam int          BD      = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] address = '0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] io_memory_write = '0;
   logic [31:0] io_memory_read;
   logic        valid_io_read;
   logic        tx;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   time        start_q[$];
   logic       abort_frame = 1'b0;

   io_uart_tx #(
      .CLK_RATE    (16),
      .BAUD_RATE   (1),
      .FIFO_DEPTH  (8),
      .BASE_ADDRESS(DATA_A)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .address        (address),
      .MemWrite       (MemWrite),
      .MemRead        (MemRead),
      .io_memory_write(io_memory_write),
      .io_memory_read (io_memory_read),
      .valid_io_read  (valid_io_read),
      .tx             (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Each bus task starts at a falling clock edge and returns at the next one.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      address         = a;
      io_memory_write = d;
      MemWrite        = 1'b1;
      MemRead         = 1'b0;
      @(negedge clk);
      MemWrite = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input logic exp_valid,
                           input string tag);
      address  = a;
      MemRead  = 1'b1;
      MemWrite = 1'b0;
      @(negedge clk);
      MemRead = 1'b0;
      check(32'(valid_io_read), 32'(exp_valid), {tag, "_valid"});
      check(io_memory_read, exp, tag);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input int max_cycles, input string tag);
      for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
      check(32'(exp_q.size()), 32'd0, tag);
   endtask

   // Serial receiver: samples each bit in its middle and scores the decoded byte.
   initial begin
      forever begin
         logic [7:0] rx_byte;
         logic       skip;
         @(negedge tx);
         start_q.push_back($time);
         skip = abort_frame;
         repeat (BD / 2) @(posedge clk);
         #1;
         if (!skip) check(32'(tx), 32'd0, "start_bit");
         for (int i = 0; i < 8; i++) begin
            repeat (BD) @(posedge clk);
            #1;
            rx_byte[i] = tx;
         end
         repeat (BD) @(posedge clk);
         #1;
         if (skip) begin
            abort_frame = 1'b0;
         end else begin
            check(32'(tx), 32'd1, "stop_bit");
            check(32'(exp_q.size() != 0), 32'd1, "frame_expected");
            if (exp_q.size() != 0) check(32'(rx_byte), 32'(exp_q.pop_front()), "rx_byte");
         end
      end
   end

   initial begin
      // Reset and idle state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(1);
      check(32'(tx), 32'd1, "tx_idle_after_reset");
      check(32'(valid_io_read), 32'd0, "valid_after_reset");
      check(io_memory_read, 32'd0, "rdata_after_reset");
      bus_read(STAT_A, 32'h0000_0002, 1'b1, "status_reset");
      idle(1);
      check(32'(valid_io_read), 32'd0, "valid_one_cycle");

      // Single byte: tx falls one edge after the accepting write
      exp_q.push_back(8'h55);
      bus_write(DATA_A, 32'h55);
      check(32'(tx), 32'd1, "tx_high_before_pop");
      bus_read(STAT_A, 32'h0000_0010, 1'b1, "status_queued");
      check(32'(tx), 32'd0, "tx_start_falls");
      bus_read(STAT_A, 32'h0000_0006, 1'b1, "status_busy_first");
      for (int j = 0; j < 9; j++) begin
         idle(15);
         bus_read(STAT_A, 32'h0000_0006, 1'b1, "status_busy_frame");
      end
      drain(200, "drain_single");
      idle(20);
      bus_read(STAT_A, 32'h0000_0002, 1'b1, "status_after_frame");

      // Back-to-back frames with no idle gap
      start_q.delete();
      exp_q.push_back(8'ha5);
      exp_q.push_back(8'h3c);
      bus_write(DATA_A, 32'ha5);
      bus_write(DATA_A, 32'h3c);
      drain(500, "drain_b2b");
      check(32'(start_q.size()), 32'd2, "b2b_frame_count");
      if (start_q.size() == 2) check(32'(start_q[1] - start_q[0]), 32'(10 * BD * 10), "b2b_spacing");
      idle(20);

      // Fill the FIFO during an active frame; the ninth extra byte is dropped
      exp_q.push_back(8'h11);
      bus_write(DATA_A, 32'h11);
      for (int i = 0; i < 9; i++) begin
         if (i < 8) exp_q.push_back(8'(8'h21 + i));
         bus_write(DATA_A, 32'(8'h21 + i));
      end
      bus_read(STAT_A, 32'h0000_008d, 1'b1, "status_full_ovf");
      bus_write(STAT_A, 32'h0000_0000);
      bus_read(STAT_A, 32'h0000_008d, 1'b1, "status_no_clear");
      bus_write(STAT_A, 32'h0000_0008);
      bus_read(STAT_A, 32'h0000_0085, 1'b1, "status_ovf_cleared");
      bus_write(UNMAP_A, 32'h0000_0077);
      bus_read(STAT_A, 32'h0000_0085, 1'b1, "status_unmapped_write");
      drain(2500, "drain_burst");
      idle(200);
      bus_read(STAT_A, 32'h0000_0002, 1'b1, "status_burst_done");

      // Read contract
      bus_read(UNMAP_A, 32'h0, 1'b0, "unmapped_read");
      bus_read(DATA_A, 32'h0, 1'b1, "data_read");
      idle(1);
      check(32'(valid_io_read), 32'd0, "valid_pulse");

      // Reset during data bit 3 of 0x07 (a zero bit) aborts the frame and the queue
      abort_frame = 1'b1;
      bus_write(DATA_A, 32'h07);
      bus_write(DATA_A, 32'hf0);
      idle(69);
      check(32'(tx), 32'd0, "tx_bit3_low");
      rst = 1'b0;
      @(negedge clk);
      check(32'(tx), 32'd1, "tx_reset_midframe");
      check(32'(valid_io_read), 32'd0, "valid_in_reset");
      rst = 1'b1;
      bus_read(STAT_A, 32'h0000_0002, 1'b1, "status_after_abort");
      idle(250);
      check(32'(tx), 32'd1, "tx_idle_after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter peripheral on the processor data bus (processor clock domain), alongside the iosystem I/O decoder.
- The processor writes bytes to a DATA register. Bytes are queued in a small FIFO and shifted out serially as 8N1 frames.
- A STATUS register exposes FIFO and transmitter state.
- Read data follows the same contract as other I/O sources: registered read data plus a valid flag, muxed ahead of data-memory read data.

Parameters:
- CLK_RATE, 33_333_333: processor clock frequency in Hz.
- BAUD_RATE, 19_200: serial bit rate.
- BAUD_DIV, CLK_RATE/BAUD_RATE (integer division, 1736 at defaults): clocks per bit. Must be >= 2.
- FIFO_DEPTH, 8: transmit FIFO entries. Must be a power of 2, >= 2.
- BASE_ADDRESS, 32'h00007f30: byte address of the DATA register. STATUS is at BASE_ADDRESS+4.

Ports:
- clk, input, 1: processor clock. All logic is on the rising edge.
- rst, input, 1: reset. Synchronous, active-low (0 = reset).
- address, input, 32: data bus byte address.
- MemWrite, input, 1: bus write strobe.
- MemRead, input, 1: bus read strobe.
- io_memory_write, input, 32: write data. Only [7:0] is used for DATA; [3] is used for STATUS clear.
- io_memory_read, output, 32: registered read data.
- valid_io_read, output, 1: io_memory_read holds a valid response from this block.
- tx, output, 1: serial output, idle high.

Behaviour:
- Reset (rst==0 at an edge):
  - tx=1, io_memory_read=0, valid_io_read=0.
  - FIFO emptied (count=0, pointers=0), overflow=0.
  - FSM=IDLE, bit counter=0, baud counter=0.
  - Reset mid-frame aborts the frame: tx returns high at that edge and the queued bytes are lost.
- Decode: DATA hit = (address==BASE_ADDRESS); STATUS hit = (address==BASE_ADDRESS+4). All other addresses are ignored entirely.
- Write to DATA:
  - push = MemWrite & DATA hit.
  - The byte is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky overflow is set.
- Write to STATUS with io_memory_write[3]==1 clears overflow. If a drop and a clear occur in the same cycle, overflow ends at 1.
- Reads (1-cycle latency):
  - If MemRead and a DATA or STATUS hit occur at edge N, then after edge N valid_io_read=1 and io_memory_read holds the response.
  - Otherwise valid_io_read=0 and io_memory_read=0.
  - DATA reads return 0.
  - STATUS layout (sampled pre-edge): [0]=full (count==FIFO_DEPTH), [1]=empty (count==0), [2]=busy (FSM!=IDLE), [3]=overflow, [7:4]=count (saturates at 15), [31:8]=0.
- FIFO: circular buffer with pointer wrap modulo FIFO_DEPTH. count has width log2(FIFO_DEPTH)+1. A simultaneous push and pop leaves count unchanged.
- FSM states are IDLE, START, DATA, STOP. baud_cnt counts 0..BAUD_DIV-1, and a bit ends when baud_cnt==BAUD_DIV-1.
  - IDLE: tx=1. If count>0: pop the head into the shift register, baud_cnt=0, go to START.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for BAUD_DIV cycles per bit, LSB first. At each bit end, shift right and increment bit_idx. After bit 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles. At the final cycle, if count>0, pop and go directly to START (no idle gap); else go to IDLE.
- Latency and frame timing:
  - A write accepted at edge N into an empty FIFO while IDLE is popped at edge N+1, and tx falls after edge N+1.
  - Frame length is exactly 10*BAUD_DIV cycles.
- tx is driven from a register (glitch-free).

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release -> tx=1, valid_io_read=0, STATUS read returns 32'h00000002.
- Single byte (bench CLK_RATE=16, BAUD_RATE=1, BAUD_DIV=16): write 0x55 to 0x7f30 -> tx low for 16 cycles starting after edge N+1, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles. busy=1 throughout the frame; STATUS returns 0x02 afterwards.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles -> two 160-cycle frames with no idle gap. Decoded bytes are 0xA5 then 0x3C.
- Full/overflow: while frame 1 is active, write 9 more bytes -> STATUS=0x000000 8D (full, busy, overflow, count=8); the 9th byte is never transmitted.
- Overflow clear: write 0x8 to 0x7f34 -> overflow bit reads 0 on the next STATUS read. A simultaneous drop and clear leaves overflow at 1.
- Read contract and mid-frame reset:
  - MemRead to 0x7f38 -> valid_io_read=0.
  - A STATUS read shows valid_io_read=1 for exactly one cycle.
  - Asserting rst=0 during bit 3 -> tx=1 at the next edge and the FIFO is empty.
